// File: rtl/spi_cfg_flash_reader.sv
// spi_cfg_flash_reader: post-configuration SPI flash read engine.
// Clocks the configuration flash through STARTUP_VIRTEX6 (USRCCLKO/USRCCLKTS)
// after end-of-startup. Issues one mode-0 READ at ADDR and streams LEN bytes
// over a valid/ready byte interface.
// Build option: define SPI_FAST_READ_EN to use FAST READ (0x0B) with 8 dummy
// clocks between address and data. The port list is the same in both builds.
module spi_cfg_flash_reader #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EOS,
  input  logic        START,
  input  logic [23:0] ADDR,
  input  logic [15:0] LEN,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  DOUT,
  output logic        DOUT_VALID,
  input  logic        DOUT_READY,
  output logic        USRCCLKO,
  output logic        USRCCLKTS,
  output logic        FCS_B,
  output logic        MOSI,
  input  logic        DINSPI
);

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HDR_W  = BYTE_W + ADDR_W;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BIT_W  = 6;
  localparam int unsigned RXC_W  = 3;
  localparam int unsigned GAP_W  = $clog2(CS_GAP + 2);

  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(CS_GAP);
  localparam logic [BIT_W-1:0] CMD_BITS = BIT_W'(8);

`ifdef SPI_FAST_READ_EN
  // Dummy clocks ride at the end of the address phase with MOSI held low.
  localparam logic [BYTE_W-1:0] CMD_OP          = 8'h0B;
  localparam logic [BIT_W-1:0]  ADDR_PHASE_BITS = BIT_W'(32);
`else
  localparam logic [BYTE_W-1:0] CMD_OP          = 8'h03;
  localparam logic [BIT_W-1:0]  ADDR_PHASE_BITS = BIT_W'(24);
`endif

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]        state_q,   state_d;
  logic [DIV_W-1:0]  div_q,     div_d;
  logic              sck_q,     sck_d;
  logic              cs_b_q,    cs_b_d;
  logic              ts_q,      ts_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              valid_q,   valid_d;
  logic              fin_q,     fin_d;
  logic [HDR_W-1:0]  tx_q,      tx_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] rx_q,      rx_d;
  logic [BYTE_W-1:0] dout_q,    dout_d;
  logic [RXC_W-1:0]  rx_cnt_q,  rx_cnt_d;
  logic [LEN_W-1:0]  rem_q,     rem_d;
  logic [GAP_W-1:0]  gap_q,     gap_d;

  logic div_tc;
  logic stall;

  // Divider terminal count: the cycle in which SCK toggles.
  assign div_tc = (div_q == DIV_TC);

  // Hold the 8th rising edge of a byte while the previous byte is still unconsumed.
  assign stall = (state_q == S_DATA) && !fin_q && !sck_q &&
                 (rx_cnt_q == RXC_W'(7)) && valid_q && !DOUT_READY;

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      sck_q     <= 1'b0;
      cs_b_q    <= 1'b1;
      ts_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      fin_q     <= 1'b0;
      tx_q      <= '0;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      dout_q    <= '0;
      rx_cnt_q  <= '0;
      rem_q     <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sck_q     <= sck_d;
      cs_b_q    <= cs_b_d;
      ts_q      <= ts_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      fin_q     <= fin_d;
      tx_q      <= tx_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      dout_q    <= dout_d;
      rx_cnt_q  <= rx_cnt_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
    end
  end

  // Next-state logic: sequencing, SCK generation, shifting and output handshake.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    sck_d     = sck_q;
    cs_b_d    = cs_b_q;
    ts_d      = ts_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    fin_d     = fin_q;
    tx_d      = tx_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    dout_d    = dout_q;
    rx_cnt_d  = rx_cnt_q;
    rem_d     = rem_q;
    gap_d     = gap_q;

    // A consumed byte frees the output; a same-cycle load below re-asserts it.
    if (valid_q && DOUT_READY) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (START && EOS) begin
          if (LEN != '0) begin
            state_d   = S_CMD;
            busy_d    = 1'b1;
            ts_d      = 1'b0;
            cs_b_d    = 1'b0;
            tx_d      = {CMD_OP, ADDR};
            rem_d     = LEN;
            div_d     = '0;
            sck_d     = 1'b0;
            bit_cnt_d = '0;
            rx_cnt_d  = '0;
            fin_d     = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_CMD, S_ADDR, S_DATA: begin
        if (!div_tc) begin
          div_d = div_q + DIV_W'(1);
        end else if (!stall) begin
          div_d = '0;
          sck_d = !sck_q;
          if (!sck_q) begin
            // Rising-edge slot: count header bits, sample read data.
            if (state_q != S_DATA) begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end else begin
              rx_d     = {rx_q[BYTE_W-2:0], DINSPI};
              rx_cnt_d = rx_cnt_q + RXC_W'(1);
              if (rx_cnt_q == RXC_W'(7)) begin
                dout_d  = {rx_q[BYTE_W-2:0], DINSPI};
                valid_d = 1'b1;
                rem_d   = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                  fin_d = 1'b1;
                end
              end
            end
          end else begin
            // Falling-edge slot: advance MOSI and change phase.
            tx_d = tx_q << 1;
            if ((state_q == S_CMD) && (bit_cnt_q == CMD_BITS)) begin
              state_d   = S_ADDR;
              bit_cnt_d = '0;
            end else if ((state_q == S_ADDR) && (bit_cnt_q == ADDR_PHASE_BITS)) begin
              state_d   = S_DATA;
              bit_cnt_d = '0;
            end else if ((state_q == S_DATA) && fin_q) begin
              state_d = S_GAP;
              cs_b_d  = 1'b1;
              gap_d   = '0;
            end
          end
        end
      end

      S_GAP: begin
        if (gap_q != GAP_MAX) begin
          gap_d = gap_q + GAP_W'(1);
        end
        if (((32'(gap_q) + 32'd1) >= CS_GAP) && !valid_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ts_d    = 1'b1;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign DOUT       = dout_q;
  assign DOUT_VALID = valid_q;
  assign USRCCLKO   = sck_q;
  assign USRCCLKTS  = ts_q;
  assign FCS_B      = cs_b_q;
  assign MOSI       = tx_q[HDR_W-1];

endmodule

// File: tb/tb_spi_cfg_flash_reader.sv
// Bench for spi_cfg_flash_reader: three instances (CLK_DIV 2, 1, 5) driven by
// tasks that also play the flash device and the byte consumer.
module tb_spi_cfg_flash_reader;

  localparam int NI = 3;
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD_OP = 8'h0B;
  localparam int         HDR    = 40;
`else
  localparam logic [7:0] CMD_OP = 8'h03;
  localparam int         HDR    = 32;
`endif

  function automatic int unsigned div_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        eos;
  logic        start [NI];
  logic [23:0] addr  [NI];
  logic [15:0] len   [NI];
  logic        ready [NI];
  logic        din   [NI];
  logic        busy  [NI];
  logic        done  [NI];
  logic [7:0]  dout  [NI];
  logic        dval  [NI];
  logic        sck   [NI];
  logic        ts    [NI];
  logic        fcs   [NI];
  logic        mosi  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    spi_cfg_flash_reader #(.CLK_DIV(div_of(g)), .CS_GAP(4)) u_dut (
      .CLK(clk), .RST_N(rst_n), .EOS(eos), .START(start[g]), .ADDR(addr[g]),
      .LEN(len[g]), .BUSY(busy[g]), .DONE(done[g]), .DOUT(dout[g]),
      .DOUT_VALID(dval[g]), .DOUT_READY(ready[g]), .USRCCLKO(sck[g]),
      .USRCCLKTS(ts[g]), .FCS_B(fcs[g]), .MOSI(mosi[g]), .DINSPI(din[g])
    );
  end

  int checks = 0;
  int errors = 0;

  // Flash contents: one byte per low address byte.
  logic [7:0] mem [256];
  function automatic logic [7:0] mem_at(input logic [23:0] a);
    return mem[a[7:0]];
  endfunction

  // Expected bits seen on MOSI over the header rising edges.
  function automatic logic [63:0] exp_hdr(input logic [23:0] a);
    logic [63:0] e;
    e = {32'b0, CMD_OP, a};
    if (HDR == 40) e = e << 8;
    return e;
  endfunction

  // Observations from the last transaction.
  int         o_rises, o_setup, o_period, o_done_cnt, o_ts_bad, o_mosi_bad;
  int         o_frz_a, o_frz_b;
  logic       o_timeout, o_busy_at_done, o_frz_sck;
  logic [63:0] o_hdr;
  logic [7:0] o_bytes [$];

  // Run one read on instance i while modelling the flash and the consumer.
  // mode 0: always ready, 1: random ready, 2: hold ready low 100 cycles at first byte.
  task automatic do_read(input int i, input logic [23:0] a, input logic [15:0] n,
                         input int mode, input int inj_cyc, input logic [23:0] inj_addr);
    int cyc, budget, first_rise, cs_fall, hold, k, post;
    logic psck, pcs, hold_started;
    logic [7:0] b;
    o_rises = 0; o_setup = -1; o_period = -1; o_done_cnt = 0; o_ts_bad = 0;
    o_mosi_bad = 0; o_frz_a = -1; o_frz_b = -1; o_timeout = 1'b0;
    o_busy_at_done = 1'bx; o_frz_sck = 1'bx; o_hdr = '0; o_bytes.delete();
    budget = (HDR + 8 * int'(n)) * 2 * int'(div_of(i)) * 4 + 400;
    psck = 1'b0; pcs = 1'b1; hold = 0; hold_started = 1'b0; post = -1;
    first_rise = 0; cs_fall = 0; cyc = 0;
    @(negedge clk);
    start[i] = 1'b1; addr[i] = a; len[i] = n; ready[i] = (mode != 2); din[i] = 1'b0;
    while (post != 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start[i] = 1'b0;
      if (inj_cyc > 0 && cyc == inj_cyc) begin
        start[i] = 1'b1; addr[i] = inj_addr; len[i] = 16'd3;
      end
      if (inj_cyc > 0 && cyc == inj_cyc + 1) start[i] = 1'b0;
      if (pcs && !fcs[i]) cs_fall = cyc;
      if (!psck && sck[i]) begin
        o_rises++;
        if (o_rises == 1) begin first_rise = cyc; o_setup = cyc - cs_fall; end
        if (o_rises == 2) o_period = cyc - first_rise;
        if (o_rises <= HDR) o_hdr = {o_hdr[62:0], mosi[i]};
        else if (mosi[i] !== 1'b0) o_mosi_bad++;
      end
      if (psck && !sck[i] && !fcs[i] && o_rises >= HDR) begin
        k = o_rises - HDR;
        b = mem_at(a + 24'(k / 8));
        din[i] = b[7 - (k % 8)];
      end
      if (mode == 2) begin
        if (!hold_started && dval[i]) begin hold_started = 1'b1; hold = 100; end
        if (hold > 0) begin
          ready[i] = 1'b0;
          hold--;
          if (hold == 50) o_frz_a = o_rises;
          if (hold == 0) begin o_frz_b = o_rises; o_frz_sck = sck[i]; end
        end else begin
          ready[i] = 1'b1;
        end
      end else if (mode == 1) begin
        ready[i] = 1'($urandom_range(0, 1));
      end else begin
        ready[i] = 1'b1;
      end
      if (dval[i] && ready[i]) o_bytes.push_back(dout[i]);
      if (ts[i] !== !busy[i]) o_ts_bad++;
      if (done[i]) begin
        o_done_cnt++;
        o_busy_at_done = busy[i];
        if (post < 0) post = 4;
      end
      if (post > 0) post--;
      if (cyc >= budget) begin o_timeout = 1'b1; post = 0; end
      psck = sck[i]; pcs = fcs[i];
    end
    ready[i] = 1'b1;
  endtask

  task automatic test_reset();
    logic [14:0] got;
    rst_n = 1'b0; eos = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; addr[i] = '0; len[i] = '0; ready[i] = 1'b1; din[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      got = {sck[i], ts[i], fcs[i], mosi[i], busy[i], done[i], dval[i], dout[i]};
      checks++;
      if (got !== 15'b0110_000_00000000) begin
        errors++; $display("FAIL reset_values inst %0d: got %b expected %b", i, got, 15'b0110_000_00000000);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_read();
    logic [7:0] exp_b [2];
    exp_b[0] = 8'hA5; exp_b[1] = 8'h3C;
    do_read(0, 24'h012345, 16'd2, 0, 0, 24'h0);
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b expected 0", o_timeout); end
    checks++; if (o_hdr !== exp_hdr(24'h012345)) begin errors++; $display("FAIL basic_mosi: got %h expected %h", o_hdr, exp_hdr(24'h012345)); end
    checks++; if (o_rises !== HDR + 16) begin errors++; $display("FAIL basic_rises: got %0d expected %0d", o_rises, HDR + 16); end
    checks++; if (o_bytes.size() !== 2) begin errors++; $display("FAIL basic_nbytes: got %0d expected 2", o_bytes.size()); end
    for (int j = 0; j < 2 && j < o_bytes.size(); j++) begin
      checks++;
      if (o_bytes[j] !== exp_b[j]) begin errors++; $display("FAIL basic_byte%0d: got %h expected %h", j, o_bytes[j], exp_b[j]); end
    end
    checks++; if (o_done_cnt !== 1) begin errors++; $display("FAIL basic_done: got %0d expected 1", o_done_cnt); end
    checks++; if (o_busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", o_busy_at_done); end
    checks++; if (o_ts_bad !== 0) begin errors++; $display("FAIL basic_tristate: got %0d expected 0", o_ts_bad); end
    checks++; if (o_mosi_bad !== 0) begin errors++; $display("FAIL basic_mosi_data: got %0d expected 0", o_mosi_bad); end
  endtask

  task automatic test_gating();
    int bad;
    logic [23:0] a;
    logic [7:0] b;
    // EOS low: START ignored.
    @(negedge clk);
    eos = 1'b0; start[0] = 1'b1; len[0] = 16'd5; addr[0] = 24'h000010;
    @(negedge clk);
    start[0] = 1'b0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (busy[0] !== 1'b0 || fcs[0] !== 1'b1 || done[0] !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL gate_eos: got %0d bad cycles expected 0", bad); end
    eos = 1'b1;
    // LEN zero: DONE one cycle later, nothing else moves.
    start[0] = 1'b1; len[0] = 16'd0;
    @(negedge clk);
    start[0] = 1'b0;
    checks++; if ({done[0], busy[0], fcs[0]} !== 3'b101) begin errors++; $display("FAIL gate_len0_done: got %b expected 101", {done[0], busy[0], fcs[0]}); end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || sck[0] !== 1'b0 || busy[0] !== 1'b0 || fcs[0] !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL gate_len0_quiet: got %0d bad cycles expected 0", bad); end
    // START while busy: ignored.
    a = 24'($urandom);
    do_read(0, a, 16'd1, 0, 5, ~a);
    checks++; if (o_hdr !== exp_hdr(a)) begin errors++; $display("FAIL gate_busy_addr: got %h expected %h", o_hdr, exp_hdr(a)); end
    checks++; if (o_rises !== HDR + 8) begin errors++; $display("FAIL gate_busy_rises: got %0d expected %0d", o_rises, HDR + 8); end
    checks++; if (o_done_cnt !== 1) begin errors++; $display("FAIL gate_busy_done: got %0d expected 1", o_done_cnt); end
    b = mem_at(a);
    checks++; if (o_bytes.size() !== 1 || o_bytes[0] !== b) begin errors++; $display("FAIL gate_busy_data: got %0d bytes first %h expected 1 byte %h", o_bytes.size(), (o_bytes.size() > 0) ? o_bytes[0] : 8'hxx, b); end
  endtask

  task automatic test_backpressure();
    logic [23:0] a;
    logic [7:0] b;
    a = 24'($urandom);
    do_read(0, a, 16'd4, 2, 0, 24'h0);
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b expected 0", o_timeout); end
    checks++; if (o_frz_a !== HDR + 15 || o_frz_b !== HDR + 15) begin errors++; $display("FAIL bp_frozen_edges: got %0d/%0d expected %0d", o_frz_a, o_frz_b, HDR + 15); end
    checks++; if (o_frz_sck !== 1'b0) begin errors++; $display("FAIL bp_sck_low: got %b expected 0", o_frz_sck); end
    checks++; if (o_rises !== HDR + 32) begin errors++; $display("FAIL bp_rises: got %0d expected %0d", o_rises, HDR + 32); end
    checks++; if (o_bytes.size() !== 4) begin errors++; $display("FAIL bp_nbytes: got %0d expected 4", o_bytes.size()); end
    for (int j = 0; j < o_bytes.size() && j < 4; j++) begin
      b = mem_at(a + 24'(j));
      checks++; if (o_bytes[j] !== b) begin errors++; $display("FAIL bp_byte%0d: got %h expected %h", j, o_bytes[j], b); end
    end
    checks++; if (o_done_cnt !== 1) begin errors++; $display("FAIL bp_done: got %0d expected 1", o_done_cnt); end
  endtask

  task automatic test_divider();
    logic [23:0] a;
    logic [15:0] n;
    logic [7:0] b;
    for (int i = 1; i < NI; i++) begin
      a = 24'($urandom);
      n = 16'($urandom_range(1, 3));
      do_read(i, a, n, 0, 0, 24'h0);
      checks++; if (o_setup !== int'(div_of(i))) begin errors++; $display("FAIL div_setup inst %0d: got %0d expected %0d", i, o_setup, div_of(i)); end
      checks++; if (o_period !== 2 * int'(div_of(i))) begin errors++; $display("FAIL div_period inst %0d: got %0d expected %0d", i, o_period, 2 * div_of(i)); end
      checks++; if (o_rises !== HDR + 8 * int'(n)) begin errors++; $display("FAIL div_rises inst %0d: got %0d expected %0d", i, o_rises, HDR + 8 * int'(n)); end
      checks++; if (o_bytes.size() !== int'(n)) begin errors++; $display("FAIL div_nbytes inst %0d: got %0d expected %0d", i, o_bytes.size(), n); end
      for (int j = 0; j < o_bytes.size() && j < int'(n); j++) begin
        b = mem_at(a + 24'(j));
        checks++; if (o_bytes[j] !== b) begin errors++; $display("FAIL div_byte inst %0d idx %0d: got %h expected %h", i, j, o_bytes[j], b); end
      end
    end
  endtask

  task automatic test_random();
    int i;
    logic [23:0] a;
    logic [15:0] n;
    logic [7:0] b;
    for (int t = 0; t < 6; t++) begin
      i = $urandom_range(0, NI - 1);
      a = 24'($urandom);
      n = 16'($urandom_range(1, 6));
      do_read(i, a, n, 1, 0, 24'h0);
      checks++; if (o_timeout !== 1'b0 || o_done_cnt !== 1) begin errors++; $display("FAIL rand_done run %0d: timeout %b done %0d expected 0/1", t, o_timeout, o_done_cnt); end
      checks++; if (o_hdr !== exp_hdr(a)) begin errors++; $display("FAIL rand_mosi run %0d: got %h expected %h", t, o_hdr, exp_hdr(a)); end
      checks++; if (o_bytes.size() !== int'(n)) begin errors++; $display("FAIL rand_nbytes run %0d: got %0d expected %0d", t, o_bytes.size(), n); end
      for (int j = 0; j < o_bytes.size() && j < int'(n); j++) begin
        b = mem_at(a + 24'(j));
        checks++; if (o_bytes[j] !== b) begin errors++; $display("FAIL rand_byte run %0d idx %0d: got %h expected %h", t, j, o_bytes[j], b); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int rises, cyc, bad;
    logic psck, hit;
    logic [14:0] got;
    logic [23:0] a;
    logic [7:0] b;
    rises = 0; cyc = 0; psck = 1'b0; hit = 1'b0;
    @(negedge clk);
    start[0] = 1'b1; addr[0] = 24'($urandom); len[0] = 16'd6; ready[0] = 1'b1;
    while (!hit && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start[0] = 1'b0;
      if (!psck && sck[0]) rises++;
      psck = sck[0];
      if (rises == HDR + 19) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach: got %0d edges expected %0d", rises, HDR + 19); end
    rst_n = 1'b0;
    #1;
    got = {sck[0], ts[0], fcs[0], mosi[0], busy[0], done[0], dval[0], dout[0]};
    checks++; if (got !== 15'b0110_000_00000000) begin errors++; $display("FAIL rstmid_values: got %b expected %b", got, 15'b0110_000_00000000); end
    bad = 0;
    repeat (2) begin @(negedge clk); if (done[0] !== 1'b0) bad++; end
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); if (done[0] !== 1'b0 || busy[0] !== 1'b0) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d bad cycles expected 0", bad); end
    a = 24'($urandom);
    do_read(0, a, 16'd3, 0, 0, 24'h0);
    checks++; if (o_done_cnt !== 1 || o_bytes.size() !== 3) begin errors++; $display("FAIL rstmid_after: done %0d bytes %0d expected 1/3", o_done_cnt, o_bytes.size()); end
    for (int j = 0; j < o_bytes.size() && j < 3; j++) begin
      b = mem_at(a + 24'(j));
      checks++; if (o_bytes[j] !== b) begin errors++; $display("FAIL rstmid_byte%0d: got %h expected %h", j, o_bytes[j], b); end
    end
  endtask

  initial begin
    for (int j = 0; j < 256; j++) mem[j] = 8'($urandom);
    mem[8'h45] = 8'hA5;
    mem[8'h46] = 8'h3C;
    test_reset();
    test_basic_read();
    test_gating();
    test_backpressure();
    test_divider();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
